feynman_decode_fifo: RTL and testbench
======================================

FEYNMAN_DECODE_FIFO -- requirements
Module: feynman_decode_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit-width of each p/q/a/b lane vector.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries, power of two, 2..16.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: upstream Feynman-gate bank presents a valid (p,q) pair.
REQ-006 SHALL have port in_ready  output  1: block accepts the pair this cycle.
REQ-007 SHALL have port in_p  input  WIDTH: per-lane Feynman output p (p=a).
REQ-008 SHALL have port in_q  input  WIDTH: per-lane Feynman output q (q=a^b).
REQ-009 SHALL have port out_valid  output  1: head entry available.
REQ-010 SHALL have port out_ready  input  1: downstream consumes head this cycle.
REQ-011 SHALL have port out_a  output  WIDTH: recovered a.
REQ-012 SHALL have port out_b  output  WIDTH: recovered b.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1: current occupancy.
REQ-014 SHALL have port pair_cnt  output  16: count of completed output transfers, saturating.

Function
REQ-015 SHALL decode on push, per lane: stored a = in_p, stored b = in_p ^ in_q (inverse Feynman gate).
REQ-016 SHALL push when in_valid && in_ready; SHALL pop when out_valid && out_ready.
REQ-017 SHALL drive in_ready = (level < DEPTH), combinationally from registered level only, never from out_ready.
REQ-018 SHALL drive out_valid = (level != 0); out_a/out_b SHALL be the head entry and held stable while out_valid && !out_ready.
REQ-019 SHALL have latency of 1 cycle: a pair pushed at edge N is visible on out_a/out_b with out_valid=1 after edge N when FIFO was empty.
REQ-020 SHALL have no combinational path from in_* to out_*.
REQ-021 SHALL keep level unchanged on simultaneous push and pop when 0 < level < DEPTH; order preserved (first-in first-out).
REQ-022 SHALL block pushes when full, even if a pop occurs the same cycle; that cycle performs pop only, level decrements to DEPTH-1.
REQ-023 SHALL ignore out_ready when empty; no pop, pair_cnt unchanged, no pointer movement.
REQ-024 SHALL wrap read/write pointers modulo DEPTH with no skipped or repeated entry.
REQ-025 SHALL increment pair_cnt by 1 per pop and hold at 16'hFFFF once reached.
REQ-026 SHALL ignore in_p/in_q values when in_valid=0, including X.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force level=0, out_valid=0, in_ready=0, pair_cnt=0, pointers=0, out_a=0, out_b=0.
REQ-028 SHALL raise in_ready=1 on the first rising edge after rst_n deasserts; no push on that edge.
REQ-029 SHALL discard all stored entries on reset asserted mid-operation; no stale entry reappears after release.

Verification
REQ-030 Single pair: WIDTH=4, push p=4'b1010, q=4'b0110 -> next cycle out_valid=1, out_a=4'b1010, out_b=4'b1100; pop -> pair_cnt=1, level=0.
REQ-031 Exhaustive lanes: push all 16x16 (a,b) combos encoded as p=a, q=a^b with out_ready=1 -> every output equals original (a,b), in order, pair_cnt=256.
REQ-032 Full/backpressure: out_ready=0, push 5 pairs into DEPTH=4 -> 4 accepted, in_ready=0, level=4; 5th held upstream and accepted after one pop.
REQ-033 Full + simultaneous: level=4, in_valid=1, out_ready=1 -> pop only, level=3, in_ready=1 next cycle.
REQ-034 Reset mid-stream: level=3, assert rst_n=0 between edges -> outputs zero immediately; after release out_valid=0 until new push.
REQ-035 Saturation: force 65537 pops -> pair_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/feynman_decode_fifo.sv
// -----------------------------------------------------------------------------
// feynman_decode_fifo
//   Receives (p,q) pairs from a bank of reversible Feynman (CNOT) gates, undoes
//   the gate on the way in (a = p, b = p ^ q) and buffers the recovered (a,b)
//   pairs in a DEPTH-entry first-in first-out queue with valid/ready handshakes
//   on both sides.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake; in_ready depends on level only
//   in_p, in_q            Feynman gate outputs, WIDTH lanes each
//   out_valid / out_ready downstream handshake
//   out_a, out_b          recovered head entry (zero while empty)
//   level                 current occupancy, 0..DEPTH
//   pair_cnt              completed output transfers, saturates at 16'hFFFF
// -----------------------------------------------------------------------------
module feynman_decode_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_p,
  input  logic [WIDTH-1:0]           in_q,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_a,
  output logic [WIDTH-1:0]           out_b,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                pair_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q,  level_d;
  logic [15:0]      cnt_q,    cnt_d;
  // Held low through reset and the first edge after release so in_ready stays
  // low on that edge and no push can happen there.
  logic             rdy_en_q;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];

  logic push, pop;

  // in_ready looks only at registered state, so there is no ready path from
  // out_ready back to the upstream side. A full queue therefore refuses a push
  // even when a pop happens in the same cycle.
  assign in_ready  = rdy_en_q && (level_q < FULL_LVL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head is read straight from storage; gating by out_valid keeps the outputs
  // at zero while empty or in reset, when the storage contents are undefined.
  assign out_a    = out_valid ? mem_a[rd_ptr_q] : '0;
  assign out_b    = out_valid ? mem_b[rd_ptr_q] : '0;
  assign level    = level_q;
  assign pair_cnt = cnt_q;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
    if (pop && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; clearing level and the
  // pointers is enough to discard old entries, and the output gating hides the
  // undefined contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q] <= in_p;
      mem_b[wr_ptr_q] <= in_p ^ in_q;
    end
  end

endmodule

// File: tb/tb_feynman_decode_fifo.sv
module tb_feynman_decode_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_p, in_q;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_a, out_b;
  logic [2:0] level;
  logic [15:0] pair_cnt;

  int vecs = 0;
  int errs = 0;

  feynman_decode_fifo #(.WIDTH(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .level     (level),
    .pair_cnt  (pair_cnt)
  );

  always #5 clk = ~clk;

  // Idle with X data on in_p/in_q: the queue must ignore it while in_valid=0.
  task automatic go_idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_p      = 'x;
    in_q      = 'x;
  endtask

  task automatic apply_reset();
    go_idle();
    rst_n = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;   // enable edge: in_ready rises here
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_pair(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    in_p     = a;
    in_q     = a ^ b;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    go_idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (level     !== 3'd0)  begin errs++; $display("FAIL rst_level: got %0d want 0", level); end
    vecs++; if (out_valid !== 1'b0)  begin errs++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    vecs++; if (in_ready  !== 1'b0)  begin errs++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    vecs++; if (pair_cnt  !== 16'd0) begin errs++; $display("FAIL rst_pair_cnt: got %h want 0", pair_cnt); end
    vecs++; if ({out_a, out_b} !== 8'h00) begin errs++; $display("FAIL rst_out_ab: got %h want 00", {out_a, out_b}); end
    // Release between edges with a valid pair offered: first edge must not push.
    @(posedge clk); #3;
    drive_pair(4'h7, 4'h2);
    rst_n = 1'b1;
    step();
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
    vecs++; if (level    !== 3'd0) begin errs++; $display("FAIL rel_no_push: level got %0d want 0", level); end
    step();
    vecs++; if (level !== 3'd1) begin errs++; $display("FAIL rel_push2: level got %0d want 1", level); end
    vecs++; if ({out_a, out_b} !== 8'h72) begin errs++; $display("FAIL rel_data: got %h want 72", {out_a, out_b}); end
    go_idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_pair();
    apply_reset();
    in_valid = 1'b1; in_p = 4'b1010; in_q = 4'b0110;
    step();
    go_idle();
    vecs++; if (out_valid !== 1'b1)    begin errs++; $display("FAIL single_valid: got %b want 1", out_valid); end
    vecs++; if (out_a     !== 4'b1010) begin errs++; $display("FAIL single_a: got %b want 1010", out_a); end
    vecs++; if (out_b     !== 4'b1100) begin errs++; $display("FAIL single_b: got %b want 1100", out_b); end
    // Held stable without out_ready.
    step();
    vecs++; if ({out_valid, out_a, out_b} !== 9'b1_1010_1100) begin errs++; $display("FAIL single_hold: got %b want 110101100", {out_valid, out_a, out_b}); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b1;   // ready while empty must be ignored
    vecs++; if (pair_cnt !== 16'd1) begin errs++; $display("FAIL single_cnt: got %0d want 1", pair_cnt); end
    vecs++; if (level    !== 3'd0)  begin errs++; $display("FAIL single_level: got %0d want 0", level); end
    step(); step();
    vecs++; if (pair_cnt !== 16'd1) begin errs++; $display("FAIL empty_pop_cnt: got %0d want 1", pair_cnt); end
    vecs++; if ({out_valid, level} !== 4'b0_000) begin errs++; $display("FAIL empty_pop_state: got %b want 0000", {out_valid, level}); end
    go_idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_exhaustive();
    int bad = 0;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [3:0] a, b;
      a = 4'(i >> 4);
      b = 4'(i);
      drive_pair(a, b);
      step();
      // Streaming at one per cycle keeps level at 1 with the newest pair at head.
      vecs++;
      if ({out_valid, level, out_a, out_b} !== {1'b1, 3'd1, a, b}) begin
        errs++; bad++;
        if (bad < 8) $display("FAIL exh_%0d: got v=%b l=%0d a=%h b=%h want v=1 l=1 a=%h b=%h",
                              i, out_valid, level, out_a, out_b, a, b);
      end
    end
    in_valid = 1'b0; in_p = 'x; in_q = 'x;
    step();
    vecs++; if (pair_cnt !== 16'd256) begin errs++; $display("FAIL exh_cnt: got %0d want 256", pair_cnt); end
    vecs++; if (level    !== 3'd0)    begin errs++; $display("FAIL exh_level: got %0d want 0", level); end
    go_idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_full_backpressure();
    logic [3:0] ea [5];
    logic [3:0] eb [5];
    for (int k = 0; k < 5; k++) begin
      ea[k] = 4'(3 * k + 1);
      eb[k] = 4'(15 - k);
    end
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      drive_pair(ea[k], eb[k]);
      step();
    end
    vecs++; if (level    !== 3'd4) begin errs++; $display("FAIL full_level: got %0d want 4", level); end
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    // Fifth pair offered while full: held upstream.
    drive_pair(ea[4], eb[4]);
    step();
    vecs++; if (level !== 3'd4) begin errs++; $display("FAIL full_block: level got %0d want 4", level); end
    vecs++; if ({out_a, out_b} !== {ea[0], eb[0]}) begin errs++; $display("FAIL full_head_hold: got %h want %h", {out_a, out_b}, {ea[0], eb[0]}); end
    // Full with push offered and pop: pop only.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vecs++; if (level    !== 3'd3) begin errs++; $display("FAIL full_simul_level: got %0d want 3", level); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL full_simul_ready: got %b want 1", in_ready); end
    step();   // fifth pair now accepted
    in_valid = 1'b0; in_p = 'x; in_q = 'x;
    vecs++; if (level !== 3'd4) begin errs++; $display("FAIL full_fifth: level got %0d want 4", level); end
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      vecs++; if ({out_valid, out_a, out_b} !== {1'b1, ea[k], eb[k]}) begin
        errs++; $display("FAIL drain_%0d: got %h want %h", k, {out_valid, out_a, out_b}, {1'b1, ea[k], eb[k]});
      end
      step();
    end
    vecs++; if ({out_valid, level, pair_cnt} !== {1'b0, 3'd0, 16'd5}) begin errs++; $display("FAIL drain_end: got v=%b l=%0d c=%0d want v=0 l=0 c=5", out_valid, level, pair_cnt); end
    go_idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midstream();
    apply_reset();
    drive_pair(4'h1, 4'h2); step();
    drive_pair(4'h3, 4'h4); step();
    drive_pair(4'h5, 4'h6); step();
    go_idle();
    vecs++; if (level !== 3'd3) begin errs++; $display("FAIL mid_pre_level: got %0d want 3", level); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if ({out_valid, in_ready, level, out_a, out_b} !== 13'd0) begin errs++; $display("FAIL mid_rst_outs: got %h want 0", {out_valid, in_ready, level, out_a, out_b}); end
    @(posedge clk); #3 rst_n = 1'b1;
    step(); step();
    vecs++; if ({out_valid, level} !== 4'd0) begin errs++; $display("FAIL mid_no_stale: got v=%b l=%0d want 0 0", out_valid, level); end
    drive_pair(4'h9, 4'hA); step();
    go_idle();
    vecs++; if ({out_valid, level, out_a, out_b} !== {1'b1, 3'd1, 4'h9, 4'hA}) begin errs++; $display("FAIL mid_new_push: got %h want %h", {out_valid, level, out_a, out_b}, {1'b1, 3'd1, 4'h9, 4'hA}); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_saturation();
    apply_reset();
    out_ready = 1'b1;
    drive_pair(4'hC, 4'h3);
    // 65537 cycles of push; pops happen on each edge after the first.
    for (int i = 0; i < 65537; i++) begin
      @(posedge clk);
      if (i == 65535) begin
        #1;
        vecs++; if (pair_cnt !== 16'hFFFF) begin errs++; $display("FAIL sat_reach: got %h want ffff", pair_cnt); end
      end
    end
    #1;
    in_valid = 1'b0; in_p = 'x; in_q = 'x;
    step();   // final pop: 65537 pops total
    vecs++; if (pair_cnt !== 16'hFFFF) begin errs++; $display("FAIL sat_hold: got %h want ffff", pair_cnt); end
    vecs++; if (level    !== 3'd0)     begin errs++; $display("FAIL sat_level: got %0d want 0", level); end
    go_idle();
  endtask

  initial begin
    go_idle();
    rst_n = 1'b1;
    test_reset();
    test_single_pair();
    test_exhaustive();
    test_full_backpressure();
    test_reset_midstream();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
